apb_host_ctrl: RTL and testbench
================================

APB_HOST_CTRL -- requirements
Module: apb_host_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, maximum ACCESS cycles before abort (only meaningful with APB_HOST_TIMEOUT_EN).
REQ-003 SHALL have port PCLK  in  1  clock; reset PRST_N, asynchronous, active-low; clock PCLK.
REQ-004 SHALL have port PRST_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports CmdValid in 1, CmdReady out 1, CmdWrite in 1, CmdAddr in 32, CmdWdata in 32: command push handshake.
REQ-006 SHALL have ports RspValid out 1, RspReady in 1, RspRdata out 32, RspErr out 1: response handshake.
REQ-007 SHALL have APB master ports PSEL out 1, PENABLE out 1, PWRITE out 1, PADDR out 32, PWDATA out 32, PRDATA in 32, PREADY in 1, PSLVERR in 1 (slaves without PREADY/PSLVERR tie 1/0).
REQ-008 SHALL have port Busy out 1: high when queue non-empty, FSM not IDLE, or RspValid high.

Function
REQ-009 Command accepted on PCLK edge where CmdValid & CmdReady; {CmdWrite,CmdAddr,CmdWdata} pushed to FIFO.
REQ-010 CmdReady = ~full; push while full SHALL NOT occur; FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-011 FSM states IDLE, SETUP, ACCESS; IDLE -> SETUP when FIFO non-empty and RspValid low; SETUP -> ACCESS unconditionally; ACCESS -> IDLE when PREADY high (or timeout).
REQ-012 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from FIFO head, registered; ACCESS: PSEL=1, PENABLE=1, address/control/data stable.
REQ-013 FIFO head popped on IDLE -> SETUP edge; simultaneous push and pop SHALL leave count unchanged.
REQ-014 On ACCESS & PREADY edge: RspValid<=1, RspRdata<=PRDATA for read, 0 for write; RspErr<=PSLVERR.
REQ-015 RspValid, RspRdata, RspErr held until RspValid & RspReady edge, then RspValid<=0; no new SETUP while RspValid high.
REQ-016 Latency: push at edge N, idle FSM, PREADY=1 -> SETUP cycle N+1, ACCESS N+2, RspValid high N+3.
REQ-017 Outside SETUP/ACCESS PSEL=0, PENABLE=0, PWRITE=0; PADDR/PWDATA retain last value.
REQ-018 Transfers SHALL be issued strictly in FIFO order, one outstanding at a time, always passing through IDLE (minimum 3 cycles per transfer plus response handshake).

Reset
REQ-019 PRST_N low SHALL asynchronously force: FSM IDLE, FIFO empty, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, RspValid=0, RspRdata=0, RspErr=0, CmdReady=1 after release, Busy=0.
REQ-020 Reset mid-ACCESS SHALL abort the transfer with no response; queued commands discarded.

Configuration
REQ-021 Macro APB_HOST_TIMEOUT_EN defined: ACCESS cycle counter (8..16 bits, sized to TIMEOUT_CYC); when TIMEOUT_CYC ACCESS cycles elapse without PREADY, FSM -> IDLE, RspValid=1, RspErr=1, RspRdata=0.
REQ-022 Macro undefined: no counter; ACCESS waits indefinitely for PREADY; RspErr reflects PSLVERR only.

Structure
REQ-023 Shared package apb_host_pkg SHALL hold FSM state encoding constants and the command record width (65 bits: write, addr, wdata).
REQ-024 Command queue SHALL be sub-module apb_host_fifo (synchronous FIFO, push/pop/full/empty/count).

Verification
REQ-025 Write 0x0000_0010 data 0x41, PREADY=1 -> PSEL cycle N+1, PENABLE N+2, PWRITE=1, PWDATA=0x41, RspValid N+3, RspErr=0.
REQ-026 Read 0x0000_0004 with slave PRDATA=0x0000_000A, PREADY low 3 ACCESS cycles -> PADDR stable throughout, RspRdata=0xA after PREADY.
REQ-027 Push 5 commands with FIFO_DEPTH=4, RspReady=0 -> CmdReady=0 after 4th unaccepted... specifically 1 issued + 4 queued, then CmdReady=0; draining responses restores issue order.
REQ-028 PSLVERR=1 on read -> RspErr=1, RspRdata=0x0000_000A unchanged capture rule, next command proceeds.
REQ-029 APB_HOST_TIMEOUT_EN, TIMEOUT_CYC=16, PREADY=0 forever -> PSEL drops after 16 ACCESS cycles, RspErr=1, RspRdata=0.
REQ-030 Assert PRST_N low during ACCESS with 2 queued -> PSEL=0, RspValid=0, FIFO empty, Busy=0 immediately.

Source files
------------

// File: rtl/apb_host_pkg.sv
// Shared types for the APB host controller: FSM state encoding, command record
// layout and the sizing helper for the optional ACCESS timeout counter.
package apb_host_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_state_e;

  // Command record is {write, addr, wdata}.
  localparam int unsigned CmdWidth = 65;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } apb_cmd_t;

  // Width of the ACCESS cycle counter: wide enough for TIMEOUT_CYC, kept within 8..16 bits.
  function automatic int unsigned to_cnt_width(int unsigned cyc);
    int unsigned w;
    w = $clog2(cyc + 1);
    if (w < 8) w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/apb_host_fifo.sv
// Synchronous command FIFO. Depth must be a power of two so the pointers wrap
// naturally; pushes while full and pops while empty are ignored.
module apb_host_fifo
  import apb_host_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = CmdWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb_host_ctrl.sv
// APB host controller: queues commands in a FIFO and issues them one at a time
// as APB transfers (IDLE -> SETUP -> ACCESS), returning one response per command.
// Optional macro APB_HOST_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC
// cycles without PREADY and reports it as an error response.
module apb_host_ctrl
  import apb_host_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        PCLK,
  input  logic        PRST_N,
  // Command push
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdWrite,
  input  logic [31:0] CmdAddr,
  input  logic [31:0] CmdWdata,
  // Response
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRdata,
  output logic        RspErr,
  // APB master
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  // Status
  output logic        Busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  apb_cmd_t            push_cmd, head_cmd;
  logic [CmdWidth-1:0] head_raw;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0]     fifo_count;

  apb_state_e  state_q, state_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef APB_HOST_TIMEOUT_EN
  localparam int unsigned ToW = to_cnt_width(TIMEOUT_CYC);
  logic [ToW-1:0] access_cnt_q, access_cnt_d;
`endif

  assign push_cmd = '{write: CmdWrite, addr: CmdAddr, wdata: CmdWdata};
  assign head_cmd = apb_cmd_t'(head_raw);

  apb_host_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CmdWidth)
  ) u_fifo (
    .clk_i   (PCLK),
    .rst_ni  (PRST_N),
    .push_i  (CmdValid),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign CmdReady = ~fifo_full;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign RspValid = rsp_valid_q;
  assign RspRdata = rsp_rdata_q;
  assign RspErr   = rsp_err_q;
  assign Busy     = (fifo_count != '0) | (state_q != StIdle) | rsp_valid_q;

  // Transfer sequencing and next values of the registered APB/response outputs.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
`ifdef APB_HOST_TIMEOUT_EN
    access_cnt_d = access_cnt_q;
`endif

    if (rsp_valid_q && RspReady) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Wait for the previous response to be taken before issuing the next one.
        if (!fifo_empty && !rsp_valid_q) begin
          state_d   = StSetup;
          fifo_pop  = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = head_cmd.write;
          paddr_d   = head_cmd.addr;
          pwdata_d  = head_cmd.wdata;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
`ifdef APB_HOST_TIMEOUT_EN
        access_cnt_d = '0;
`endif
      end
      StAccess: begin
        if (PREADY) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end
`ifdef APB_HOST_TIMEOUT_EN
        else if (access_cnt_q == ToW'(TIMEOUT_CYC - 1)) begin
          state_d     = StIdle;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
        end else begin
          access_cnt_d = access_cnt_q + ToW'(1);
        end
`endif
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
      end
    endcase
  end

  // Single state register for the FSM and all registered outputs.
  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
`ifdef APB_HOST_TIMEOUT_EN
      access_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_HOST_TIMEOUT_EN
      access_cnt_q <= access_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_host_ctrl.sv
// Self-checking bench for apb_host_ctrl (default build): a behavioural APB slave
// checks issue order and phase stability, a response monitor pops expected
// responses from a scoreboard queue.
`timescale 1ns/1ps
module tb_apb_host_ctrl;

  logic        PCLK = 1'b0;
  logic        PRST_N = 1'b1;
  logic        CmdValid, CmdReady, CmdWrite;
  logic [31:0] CmdAddr, CmdWdata;
  logic        RspValid, RspReady, RspErr;
  logic [31:0] RspRdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        Busy;

  always #5 PCLK = ~PCLK;

  apb_host_ctrl #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (255)
  ) dut (
    .PCLK     (PCLK),
    .PRST_N   (PRST_N),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdWrite (CmdWrite),
    .CmdAddr  (CmdAddr),
    .CmdWdata (CmdWdata),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspRdata (RspRdata),
    .RspErr   (RspErr),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .Busy     (Busy)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t xfer_q[$];  // transfers the slave should see, in order
  cmd_t rsp_q[$];   // responses the monitor should see, in order

  int checks = 0;
  int failures = 0;
  int rdy_mode = 1;        // 0: hold RspReady low, 1: always high, 2: random
  bit slv_wait_rand = 0;
  int slv_wait_fixed = 0;
  int last_access_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave behaviour: read data and error are fixed functions of the address.
  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    return (a[27:0] == 28'h4) ? 32'h0000_000A : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic slv_err(input logic [31:0] a);
    return a[31:28] == 4'hE;
  endfunction

  // APB slave model
  initial begin
    cmd_t cur;
    int   wait_left;
    int   alen;
    cur = '{w: 1'b0, a: 32'h0, d: 32'h0};
    wait_left = 0;
    alen = 0;
    PREADY = 1'b0;
    PRDATA = 32'h0;
    PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PSEL && !PENABLE) begin
        chk("setup_expected", (xfer_q.size() != 0), 1);
        if (xfer_q.size() != 0) begin
          cur = xfer_q.pop_front();
          chk("setup_addr", PADDR, cur.a);
          chk("setup_write", PWRITE, cur.w);
          if (cur.w) chk("setup_wdata", PWDATA, cur.d);
        end
        wait_left = slv_wait_rand ? $urandom_range(0, 3) : slv_wait_fixed;
        alen = 0;
        PREADY = 1'b0;
        PRDATA = slv_rdata(cur.a);
        PSLVERR = slv_err(cur.a);
      end else if (PSEL && PENABLE) begin
        chk("access_addr_stable", PADDR, cur.a);
        chk("access_write_stable", PWRITE, cur.w);
        alen++;
        PREADY = (wait_left == 0);
        if (wait_left > 0) wait_left--;
        else last_access_len = alen;
      end else begin
        PREADY = 1'b0;
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    cmd_t c;
    RspReady = 1'b0;
    forever begin
      @(negedge PCLK);
      case (rdy_mode)
        0:       RspReady = 1'b0;
        1:       RspReady = 1'b1;
        default: RspReady = 1'($urandom_range(0, 1));
      endcase
      if (RspValid && RspReady) begin
        chk("rsp_expected", (rsp_q.size() != 0), 1);
        if (rsp_q.size() != 0) begin
          c = rsp_q.pop_front();
          chk("rsp_rdata", RspRdata, c.w ? 32'h0 : slv_rdata(c.a));
          chk("rsp_err", RspErr, slv_err(c.a));
        end
      end
    end
  end

  task automatic note_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c = '{w: w, a: a, d: d};
    xfer_q.push_back(c);
    rsp_q.push_back(c);
  endtask

  // Call at a negedge; returns at the negedge after acceptance.
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    CmdValid = 1'b1;
    CmdWrite = w;
    CmdAddr  = a;
    CmdWdata = d;
    while (!CmdReady && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    chk("push_ready_bound", (n < 500), 1);
    if (n < 500) begin
      @(posedge PCLK);
      note_cmd(w, a, d);
      @(negedge PCLK);
    end
    CmdValid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || Busy) && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain_bound", (n < 3000), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    CmdValid = 1'b0;
    CmdWrite = 1'b0;
    CmdAddr  = 32'h0;
    CmdWdata = 32'h0;
    #2 PRST_N = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rspvalid", RspValid, 0);
    chk("rst_rsprdata", RspRdata, 0);
    chk("rst_rsperr", RspErr, 0);
    chk("rst_busy", Busy, 0);
    PRST_N = 1'b1;
    @(negedge PCLK);
    chk("rst_cmdready", CmdReady, 1);

    // Write latency: push at edge N, SETUP N+1, ACCESS N+2, response N+3
    rdy_mode = 1;
    slv_wait_fixed = 0;
    CmdValid = 1'b1;
    CmdWrite = 1'b1;
    CmdAddr  = 32'h0000_0010;
    CmdWdata = 32'h0000_0041;
    @(posedge PCLK);
    note_cmd(1'b1, 32'h10, 32'h41);
    @(negedge PCLK);
    CmdValid = 1'b0;
    chk("lat_n_psel", PSEL, 0);
    chk("lat_n_busy", Busy, 1);
    @(negedge PCLK);
    chk("lat_n1_psel", PSEL, 1);
    chk("lat_n1_penable", PENABLE, 0);
    chk("lat_n1_pwrite", PWRITE, 1);
    chk("lat_n1_paddr", PADDR, 32'h10);
    chk("lat_n1_pwdata", PWDATA, 32'h41);
    @(negedge PCLK);
    chk("lat_n2_psel", PSEL, 1);
    chk("lat_n2_penable", PENABLE, 1);
    @(negedge PCLK);
    chk("lat_n3_rspvalid", RspValid, 1);
    chk("lat_n3_rsperr", RspErr, 0);
    chk("lat_n3_psel", PSEL, 0);
    chk("lat_n3_pwrite", PWRITE, 0);
    chk("lat_n3_paddr_kept", PADDR, 32'h10);
    wait_drain();

    // Read with three wait states
    slv_wait_fixed = 3;
    push_cmd(1'b0, 32'h0000_0004, 32'h0);
    wait_drain();
    chk("wait_access_len", last_access_len, 4);

    // Slave error on a read, then a normal write
    slv_wait_fixed = 0;
    push_cmd(1'b0, 32'hE000_0004, 32'h0);
    push_cmd(1'b1, 32'h0000_0020, 32'h1234);
    wait_drain();

    // Backpressure: one issued plus four queued fills the FIFO
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) push_cmd(1'b0, 32'h100 + 32'(i * 4), 32'h0);
    repeat (3) @(negedge PCLK);
    chk("full_cmdready", CmdReady, 0);
    chk("full_busy", Busy, 1);
    chk("full_rspvalid", RspValid, 1);
    rdy_mode = 1;
    wait_drain();
    chk("drained_cmdready", CmdReady, 1);

    // Randomized traffic with random wait states and response backpressure
    rdy_mode = 2;
    slv_wait_rand = 1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:28] = 4'hE;
      push_cmd(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    wait_drain();

    // Reset in the middle of ACCESS with commands queued
    rdy_mode = 1;
    slv_wait_rand = 0;
    slv_wait_fixed = 50;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'h200 + 32'(i * 4), 32'(i));
    begin
      int n;
      n = 0;
      while (!(PSEL && PENABLE) && n < 50) begin
        @(negedge PCLK);
        n++;
      end
      chk("midrst_in_access", (PSEL && PENABLE), 1);
    end
    PRST_N = 1'b0;
    #1;
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_rspvalid", RspValid, 0);
    chk("midrst_busy", Busy, 0);
    xfer_q.delete();
    rsp_q.delete();
    @(negedge PCLK);
    PRST_N = 1'b1;
    repeat (10) @(negedge PCLK);
    chk("postrst_busy", Busy, 0);
    chk("postrst_cmdready", CmdReady, 1);
    chk("postrst_psel", PSEL, 0);
    slv_wait_fixed = 0;
    push_cmd(1'b0, 32'h0000_0300, 32'h0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
